fft_s2p_buffer: RTL and testbench
=================================

// Module: fft_s2p_buffer
// PURPOSE
//  Input stage of the parallel FFT. Sits directly upstream of the 8-point butterfly.
//  Collects a serial stream of complex samples, one per accepted cycle, into frames of 8.
//  Presents each frame on 8 parallel complex lanes under a valid/ready handshake.
//  Ping-pong (2-bank) storage: one frame fills while the previous frame is held for downstream.
// PARAMETERS
//  NB_DATA  8  width of each real/imag sample (signed two's complement); output width identical
// PORTS
//  i_clock          in   1          clock; all state updates on rising edge
//  i_reset          in   1          synchronous, active-high reset
//  i_valid          in   1          input sample valid
//  i_data_r         in   NB_DATA    input sample, real part (signed)
//  i_data_i         in   NB_DATA    input sample, imag part (signed)
//  o_ready          out  1          input sample accepted this cycle when i_valid & o_ready
//  o_data{0..7}_r   out  NB_DATA x8 frame lanes, real parts (signed)
//  o_data{0..7}_i   out  NB_DATA x8 frame lanes, imag parts (signed)
//  o_valid          out  1          frame on o_data* is valid
//  i_ready          in   1          downstream takes frame when o_valid & i_ready
//  o_frame_done     out  1          1-cycle pulse, registered, the cycle after a frame completes fill
// BEHAVIOUR
//  State:
//   - bank[0..1][0..7] complex registers
//   - full[1:0]
//   - wr_bank, rd_bank (1 bit each)
//   - wr_idx (3 bits, 0..7)
//  Reset: banks cleared to 0, full=0, wr_bank=rd_bank=0, wr_idx=0.
//   Outputs after reset: o_valid=0, o_ready=1, o_frame_done=0, all o_data*=0.
//  Accept (i_valid & o_ready): store sample in bank[wr_bank][slot(wr_idx)]; wr_idx <= wr_idx+1 (wraps 7->0).
//  Frame complete (accept with wr_idx==7):
//   - full[wr_bank] <= 1
//   - wr_bank toggles
//   - o_frame_done pulses the next cycle
//  o_ready = ~full[wr_bank] (combinational from state only; no combinational path from i_valid or i_ready).
//  o_valid = full[rd_bank]; o_data* = bank[rd_bank] when o_valid=1, else all zero.
//  Latency: the 8th accept at edge t makes o_valid=1 from cycle t+1.
//  Release (o_valid & i_ready): full[rd_bank] <= 0; rd_bank toggles.
//  Hold: while o_valid=1 & i_ready=0, o_data* are stable.
//  Both banks full: o_ready=0 and input is stalled. No sample is dropped or overwritten.
//  Simultaneous complete-fill on one bank and release on the other, same cycle: both take effect.
//   - Sustained i_valid=1 & i_ready=1 gives gapless throughput: one frame per 8 cycles.
//  Partial frame with i_valid low: wr_idx holds; the frame resumes when i_valid returns.
//  Reset mid-operation: partial and held frames are discarded. The first accept after reset is slot 0 of a new frame.
//  Arithmetic: none. Data is passed bit-exact, no rounding, no saturation; -2^(NB_DATA-1) is preserved.
//  Frame order is preserved: frames leave in the order they were filled.
// CONFIGURATION
//  Macro FFT_S2P_BITREV_EN.
//  Defined: slot(k) = bit-reverse of k over 3 bits, so sample k lands on lane 0,4,2,6,1,5,3,7.
//   This gives the decimation-in-time input order for the butterfly.
//  Undefined: slot(k)=k (natural order); reordering is done elsewhere.
//  No other behaviour differs; latency is identical.
// TESTING
//  Reset: assert i_reset 2 cycles -> o_valid=0, o_ready=1, o_frame_done=0, every o_data*=0.
//  Single frame:
//   - Stimulus: 8 samples r=k+1, i=-(k+1), k=0..7, back-to-back; i_ready=1.
//   - o_valid=1 the cycle after the 8th accept, for 1 cycle; o_frame_done pulses at the same time.
//   - Natural order: o_data3_r=4, o_data3_i=-4.
//   - FFT_S2P_BITREV_EN: o_data1_r=5, o_data4_r=2.
//  Backpressure:
//   - Stimulus: i_ready=0, offer 20 samples.
//   - o_ready drops after the 16th accept; samples 17-20 are not accepted.
//   - Then i_ready=1: frame A (values 1..8) appears, then frame B (9..16), then o_ready=1 again.
//  Streaming: 4 frames gapless, i_valid=1 and i_ready=1 -> o_valid pulses every 8 cycles; o_ready never drops.
//  Mid-frame reset: 5 samples, reset 1 cycle, then 8 samples 0x10..0x17.
//   - Exactly one frame is emitted, containing only 0x10..0x17.
//  Extremes: samples -128 and 127 (NB_DATA=8) in real/imag -> appear bit-exact on the lanes.
//   - Held stable across a 10-cycle i_ready=0 stall.

Source files
------------

// File: rtl/fft_s2p_buffer_if.sv
// -----------------------------------------------------------------------------
// fft_s2p_buffer_if
//   Bundles the serial sample input and the 8-lane parallel frame output of
//   fft_s2p_buffer. Sample values are two's-complement; they travel as plain
//   bit vectors because the buffer never does arithmetic on them.
//
//   Parameters
//     NB_DATA        width of each real/imag sample
//   Signals
//     i_valid        input sample valid
//     i_data_r/_i    input sample real / imag part
//     o_ready        buffer can take a sample this cycle
//     o_data_r/_i    frame lanes 0..7, real / imag parts
//     o_valid        frame on o_data_* is valid
//     i_ready        downstream takes the frame this cycle
//     o_frame_done   one-cycle pulse the cycle after a frame finishes filling
//   Modports
//     slave          buffer side (takes samples, drives the frame)
//     master         environment side (drives samples, takes the frame)
// -----------------------------------------------------------------------------
interface fft_s2p_buffer_if #(
    parameter int NB_DATA = 8
);
    logic               i_valid;
    logic [NB_DATA-1:0] i_data_r;
    logic [NB_DATA-1:0] i_data_i;
    logic               o_ready;
    logic [NB_DATA-1:0] o_data_r [8];
    logic [NB_DATA-1:0] o_data_i [8];
    logic               o_valid;
    logic               i_ready;
    logic               o_frame_done;

    modport slave (
        input  i_valid,
        input  i_data_r,
        input  i_data_i,
        output o_ready,
        output o_data_r,
        output o_data_i,
        output o_valid,
        input  i_ready,
        output o_frame_done
    );

    modport master (
        output i_valid,
        output i_data_r,
        output i_data_i,
        input  o_ready,
        input  o_data_r,
        input  o_data_i,
        input  o_valid,
        output i_ready,
        input  o_frame_done
    );
endinterface

// File: rtl/fft_s2p_buffer.sv
// -----------------------------------------------------------------------------
// fft_s2p_buffer
//   Input stage of the parallel FFT. Collects a serial stream of complex
//   samples into frames of 8 and presents each frame on 8 parallel lanes to
//   the 8-point butterfly. Two banks ping-pong: one fills while the other is
//   held for downstream. Frames leave in fill order; nothing is dropped.
//
//   Configuration macro
//     FFT_S2P_BITREV_EN  defined: sample k is stored on lane bitrev3(k)
//                        (decimation-in-time order 0,4,2,6,1,5,3,7).
//                        undefined: sample k is stored on lane k.
//
//   Ports
//     i_clock   clock, all state updates on the rising edge
//     i_reset   synchronous active-high reset
//     bus       fft_s2p_buffer_if.slave (sample input, frame output)
// -----------------------------------------------------------------------------
module fft_s2p_buffer #(
    parameter int NB_DATA = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    fft_s2p_buffer_if.slave       bus
);
    localparam int NB_LANES = 8;

    logic [NB_DATA-1:0] bank_r_reg [2][NB_LANES];
    logic [NB_DATA-1:0] bank_i_reg [2][NB_LANES];
    logic [1:0]         full_reg;
    logic [1:0]         full_next;
    logic               wr_bank_reg;
    logic               rd_bank_reg;
    logic [2:0]         wr_idx_reg;
    logic               frame_done_reg;

    logic               accept;
    logic               release_frame;
    logic               complete;
    logic [2:0]         wr_slot;

    // Handshake terms depend on registered state only, so o_ready and o_valid
    // never combinationally follow i_valid or i_ready.
    assign accept        = bus.i_valid & ~full_reg[wr_bank_reg];
    assign release_frame = full_reg[rd_bank_reg] & bus.i_ready;
    assign complete      = accept & (wr_idx_reg == 3'd7);

    always_comb begin
        wr_slot = wr_idx_reg;
`ifdef FFT_S2P_BITREV_EN
        wr_slot = {wr_idx_reg[0], wr_idx_reg[1], wr_idx_reg[2]};
`endif
    end

    // A fill can only complete on the empty write bank and a release only
    // acts on the full read bank, so the two updates never hit the same bit.
    always_comb begin
        full_next = full_reg;
        if (release_frame) begin
            full_next[rd_bank_reg] = 1'b0;
        end
        if (complete) begin
            full_next[wr_bank_reg] = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            full_reg       <= '0;
            wr_bank_reg    <= 1'b0;
            rd_bank_reg    <= 1'b0;
            wr_idx_reg     <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            full_reg       <= full_next;
            frame_done_reg <= complete;
            if (accept) begin
                wr_idx_reg <= wr_idx_reg + 3'd1;
            end
            if (complete) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
            if (release_frame) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
        end
    end

    // One register pair per bank/lane, each with its own write enable.
    genvar gb, gi;
    generate
        for (gb = 0; gb < 2; gb++) begin : g_bank
            for (gi = 0; gi < NB_LANES; gi++) begin : g_lane
                logic wr_en;
                assign wr_en = accept
                             & (wr_bank_reg == gb[0])
                             & (wr_slot == gi[2:0]);

                always_ff @(posedge i_clock) begin
                    if (i_reset) begin
                        bank_r_reg[gb][gi] <= '0;
                        bank_i_reg[gb][gi] <= '0;
                    end else if (wr_en) begin
                        bank_r_reg[gb][gi] <= bus.i_data_r;
                        bank_i_reg[gb][gi] <= bus.i_data_i;
                    end
                end
            end
        end
    endgenerate

    // Lanes read as zero whenever no frame is being offered.
    generate
        for (gi = 0; gi < NB_LANES; gi++) begin : g_out
            assign bus.o_data_r[gi] = full_reg[rd_bank_reg] ? bank_r_reg[rd_bank_reg][gi] : '0;
            assign bus.o_data_i[gi] = full_reg[rd_bank_reg] ? bank_i_reg[rd_bank_reg][gi] : '0;
        end
    endgenerate

    assign bus.o_ready      = ~full_reg[wr_bank_reg];
    assign bus.o_valid      = full_reg[rd_bank_reg];
    assign bus.o_frame_done = frame_done_reg;

endmodule

// File: tb/tb_fft_s2p_buffer.sv
// -----------------------------------------------------------------------------
// tb_fft_s2p_buffer
//   Directed bench for fft_s2p_buffer: reset state, single frame, backpressure
//   with both banks full, gapless streaming, mid-frame reset and extreme
//   values held across a stall. Inputs change and outputs are sampled on the
//   falling edge; the DUT updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_fft_s2p_buffer;
    localparam int NB = 8;

    logic clk;
    logic srst;
    int   n_vec;
    int   n_err;

    fft_s2p_buffer_if #(.NB_DATA(NB)) bus ();

    fft_s2p_buffer #(.NB_DATA(NB)) dut (
        .i_clock (clk),
        .i_reset (srst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane on which the k-th sample of a frame is expected.
`ifdef FFT_S2P_BITREV_EN
    int lane_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    int lane_tab [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int r, input int i);
        bus.i_valid  = v;
        bus.i_data_r = 8'(r);
        bus.i_data_i = 8'(i);
    endtask

    // Frame whose sample k has real = base+k and imag = -(base+k).
    task automatic check_frame(input string tag, input int base);
        logic [7:0] er;
        logic [7:0] ei;
        for (int k = 0; k < 8; k++) begin
            er = 8'(base + k);
            ei = 8'(-(base + k));
            check($sformatf("%s_r%0d", tag, k), 32'(bus.o_data_r[lane_tab[k]]), 32'(er));
            check($sformatf("%s_i%0d", tag, k), 32'(bus.o_data_i[lane_tab[k]]), 32'(ei));
        end
    endtask

    logic [7:0] xr [8];
    logic [7:0] xi [8];
    int         n_frames;

    initial begin
        n_vec = 0;
        n_err = 0;
        srst  = 1'b1;
        bus.i_ready = 1'b0;
        drive(1'b0, 0, 0);

        // ---------------- reset ----------------
        step();
        step();
        srst = 1'b0;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_done",  32'(bus.o_frame_done), 32'd0);
        for (int l = 0; l < 8; l++) begin
            check($sformatf("rst_r%0d", l), 32'(bus.o_data_r[l]), 32'd0);
            check($sformatf("rst_i%0d", l), 32'(bus.o_data_i[l]), 32'd0);
        end

        // ---------------- single frame ----------------
        bus.i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k + 1, -(k + 1));
            check("single_ready", 32'(bus.o_ready), 32'd1);
            check("single_novalid", 32'(bus.o_valid), 32'd0);
            step();
        end
        drive(1'b0, 0, 0);
        check("single_valid", 32'(bus.o_valid), 32'd1);
        check("single_done",  32'(bus.o_frame_done), 32'd1);
        check_frame("single", 1);
`ifdef FFT_S2P_BITREV_EN
        check("single_d1r", 32'(bus.o_data_r[1]), 32'd5);
        check("single_d4r", 32'(bus.o_data_r[4]), 32'd2);
`else
        check("single_d3r", 32'(bus.o_data_r[3]), 32'd4);
        check("single_d3i", 32'(bus.o_data_i[3]), 32'h0fc);
`endif
        step();
        check("single_after_valid", 32'(bus.o_valid), 32'd0);
        check("single_after_done",  32'(bus.o_frame_done), 32'd0);
        check("single_after_r0",    32'(bus.o_data_r[0]), 32'd0);

        // ---------------- backpressure ----------------
        bus.i_ready = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            drive(1'b1, n, -n);
            check($sformatf("bp_ready%0d", n), 32'(bus.o_ready), 32'(n <= 16));
            check($sformatf("bp_done%0d", n), 32'(bus.o_frame_done), 32'(n == 9 || n == 17));
            step();
        end
        drive(1'b0, 0, 0);
        check("bp_heldA_valid", 32'(bus.o_valid), 32'd1);
        check_frame("bp_heldA", 1);
        bus.i_ready = 1'b1;
        check_frame("bp_A", 1);
        step();
        check("bp_B_valid", 32'(bus.o_valid), 32'd1);
        check("bp_B_ready", 32'(bus.o_ready), 32'd1);
        check_frame("bp_B", 9);
        step();
        check("bp_empty_valid", 32'(bus.o_valid), 32'd0);
        check("bp_empty_ready", 32'(bus.o_ready), 32'd1);

        // ---------------- streaming ----------------
        for (int c = 0; c < 32; c++) begin
            drive(1'b1, c + 1, -(c + 1));
            check($sformatf("st_ready%0d", c), 32'(bus.o_ready), 32'd1);
            check($sformatf("st_valid%0d", c), 32'(bus.o_valid), 32'(c >= 8 && c % 8 == 0));
            if (c >= 8 && c % 8 == 0) begin
                check_frame($sformatf("st_f%0d", c / 8 - 1), 8 * (c / 8 - 1) + 1);
            end
            step();
        end
        drive(1'b0, 0, 0);
        check("st_last_valid", 32'(bus.o_valid), 32'd1);
        check_frame("st_f3", 25);
        step();
        check("st_end_valid", 32'(bus.o_valid), 32'd0);

        // ---------------- mid-frame reset ----------------
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'h50 + k, -(8'h50 + k));
            step();
        end
        drive(1'b0, 0, 0);
        srst = 1'b1;
        step();
        srst = 1'b0;
        check("mr_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mr_rst_ready", 32'(bus.o_ready), 32'd1);
        n_frames = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 8'h10 + k, -(8'h10 + k));
            if (bus.o_valid) n_frames++;
            step();
        end
        drive(1'b0, 0, 0);
        check("mr_valid", 32'(bus.o_valid), 32'd1);
        check_frame("mr", 8'h10);
        for (int c = 0; c < 11; c++) begin
            if (bus.o_valid) n_frames++;
            step();
        end
        check("mr_frames", 32'(n_frames), 32'd1);

        // ---------------- extremes held across a stall ----------------
        bus.i_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            xr[k] = (k % 2 == 0) ? 8'h80 : 8'h7f;
            xi[k] = (k % 2 == 0) ? 8'h7f : 8'h80;
            drive(1'b1, int'(xr[k]), int'(xi[k]));
            step();
        end
        drive(1'b0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("ext_valid%0d", c), 32'(bus.o_valid), 32'd1);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("ext%0d_r%0d", c, k), 32'(bus.o_data_r[lane_tab[k]]), 32'(xr[k]));
                check($sformatf("ext%0d_i%0d", c, k), 32'(bus.o_data_i[lane_tab[k]]), 32'(xi[k]));
            end
            step();
        end
        bus.i_ready = 1'b1;
        step();
        check("ext_released", 32'(bus.o_valid), 32'd0);
        check("ext_ready",    32'(bus.o_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
